// File: rtl/gpio_ext.sv
// APB-controlled GPIO block: per-pin input synchronizer, optional glitch filter,
// edge/level interrupt detection with W1C status, and set/clear/toggle output access.
module gpio_ext #(
    parameter int unsigned NUM_PINS    = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_WIDTH  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         PADDR,
    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [31:0]         PWDATA,
    output logic [31:0]         PRDATA,
    output logic                PREADY,
    output logic                PSLVERR,
    input  logic [NUM_PINS-1:0] r_data,
    output logic [NUM_PINS-1:0] w_data,
    output logic [NUM_PINS-1:0] en_data,
    output logic                interrupt
);

    typedef logic [NUM_PINS-1:0] pins_t;

    localparam logic [7:0] AddrData     = 8'h00;
    localparam logic [7:0] AddrEn       = 8'h04;
    localparam logic [7:0] AddrIntrEn   = 8'h08;
    localparam logic [7:0] AddrPosEn    = 8'h0C;
    localparam logic [7:0] AddrNegEn    = 8'h10;
    localparam logic [7:0] AddrIntrClr  = 8'h14;
    localparam logic [7:0] AddrIntrStat = 8'h18;
    localparam logic [7:0] AddrLvlEn    = 8'h1C;
    localparam logic [7:0] AddrFiltEn   = 8'h20;
    localparam logic [7:0] AddrFiltThr  = 8'h24;
    localparam logic [7:0] AddrSet      = 8'h28;
    localparam logic [7:0] AddrClr      = 8'h2C;
    localparam logic [7:0] AddrTgl      = 8'h30;

    logic [7:0] addr;
    logic       access, mapped, wr_bad, rd_bad, err, wr_en, rd_en;
    pins_t      pw;
    logic       unused_bits;

    pins_t w_q, en_q, intr_en_q, pos_en_q, neg_en_q, stat_q, lvl_en_q, filt_en_q;
    logic [FILT_WIDTH-1:0] filt_thr_q;
    pins_t sync_q [SYNC_STAGES];
    pins_t filt_q, filt_d, prev_q, synced, filtered;
    logic [FILT_WIDTH-1:0] cnt_q [NUM_PINS];
    logic [FILT_WIDTH-1:0] cnt_d [NUM_PINS];
    logic  cnt_clr;
    pins_t edge_ev, lvl_ev, ev, clr_mask, stat_d;
    logic  irq_q;
    logic [31:0] rdata;

    assign addr        = PADDR[7:0];
    assign pw          = PWDATA[NUM_PINS-1:0];
    assign unused_bits = ^{PADDR[31:8], PWDATA};
    assign access      = PSEL & PENABLE & ~rst;

    always_comb begin
        case (addr)
            AddrData, AddrEn, AddrIntrEn, AddrPosEn, AddrNegEn, AddrIntrClr, AddrIntrStat,
            AddrLvlEn, AddrFiltEn, AddrFiltThr, AddrSet, AddrClr, AddrTgl: mapped = 1'b1;
            default: mapped = 1'b0;
        endcase
    end

    assign wr_bad  = (addr == AddrIntrStat);
    assign rd_bad  = (addr == AddrIntrClr) | (addr == AddrSet) | (addr == AddrClr) |
                     (addr == AddrTgl);
    assign err     = access & (~mapped | (PWRITE ? wr_bad : rd_bad));
    assign wr_en   = access & PWRITE & ~err;
    assign rd_en   = access & ~PWRITE & ~err;
    assign PSLVERR = err;
    assign PREADY  = 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            w_q        <= '0;
            en_q       <= '0;
            intr_en_q  <= '0;
            pos_en_q   <= '0;
            neg_en_q   <= '0;
            lvl_en_q   <= '0;
            filt_en_q  <= '0;
            filt_thr_q <= '0;
        end else if (wr_en) begin
            case (addr)
                AddrData:    w_q        <= pw;
                AddrEn:      en_q       <= pw;
                AddrIntrEn:  intr_en_q  <= pw;
                AddrPosEn:   pos_en_q   <= pw;
                AddrNegEn:   neg_en_q   <= pw;
                AddrLvlEn:   lvl_en_q   <= pw;
                AddrFiltEn:  filt_en_q  <= pw;
                AddrFiltThr: filt_thr_q <= PWDATA[FILT_WIDTH-1:0];
                AddrSet:     w_q        <= w_q | pw;
                AddrClr:     w_q        <= w_q & ~pw;
                AddrTgl:     w_q        <= w_q ^ pw;
                default:     ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= r_data;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign synced   = sync_q[SYNC_STAGES-1];
    // Unfiltered pins bypass filt_q so they see no extra cycle of delay.
    assign filtered = (filt_en_q & filt_q) | (~filt_en_q & synced);
    assign cnt_clr  = wr_en & ((addr == AddrFiltEn) | (addr == AddrFiltThr));

    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < NUM_PINS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (!filt_en_q[i]) begin
                filt_d[i] = synced[i];
                cnt_d[i]  = '0;
            end else if (synced[i] == filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= filt_thr_q) begin
                filt_d[i] = synced[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + FILT_WIDTH'(1);
            end
            if (cnt_clr) cnt_d[i] = '0;
        end
    end

    assign edge_ev  = (filtered & ~prev_q & pos_en_q) | (~filtered & prev_q & neg_en_q);
    assign lvl_ev   = (filtered & pos_en_q) | (~filtered & neg_en_q);
    assign ev       = (lvl_en_q & lvl_ev) | (~lvl_en_q & edge_ev);
    assign clr_mask = (wr_en && addr == AddrIntrClr) ? pw : '0;
    // New events are OR-ed in after the clear, so a coincident set wins.
    assign stat_d   = (stat_q & ~clr_mask) | (ev & intr_en_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q <= '0;
            prev_q <= '0;
            stat_q <= '0;
            irq_q  <= 1'b0;
            for (int i = 0; i < NUM_PINS; i++) cnt_q[i] <= '0;
        end else begin
            filt_q <= filt_d;
            prev_q <= filtered;
            stat_q <= stat_d;
            irq_q  <= |(stat_q & intr_en_q);
            for (int i = 0; i < NUM_PINS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    always_comb begin
        rdata = '0;
        if (rd_en) begin
            case (addr)
                AddrData:     rdata[NUM_PINS-1:0]   = filtered;
                AddrEn:       rdata[NUM_PINS-1:0]   = en_q;
                AddrIntrEn:   rdata[NUM_PINS-1:0]   = intr_en_q;
                AddrPosEn:    rdata[NUM_PINS-1:0]   = pos_en_q;
                AddrNegEn:    rdata[NUM_PINS-1:0]   = neg_en_q;
                AddrIntrStat: rdata[NUM_PINS-1:0]   = stat_q;
                AddrLvlEn:    rdata[NUM_PINS-1:0]   = lvl_en_q;
                AddrFiltEn:   rdata[NUM_PINS-1:0]   = filt_en_q;
                AddrFiltThr:  rdata[FILT_WIDTH-1:0] = filt_thr_q;
                default:      ;
            endcase
        end
    end

    assign PRDATA    = rdata;
    assign w_data    = rst ? '0 : w_q;
    assign en_data   = rst ? '0 : en_q;
    assign interrupt = irq_q & ~rst;

endmodule

// File: tb/tb_gpio_ext.sv
// Randomized self-checking bench for gpio_ext against a cycle-level behavioural model
// built from the register, filter and interrupt rules.
module tb_gpio_ext;

    localparam int S = 2;

    logic        clk, rst;
    logic [31:0] paddr, pwdata, prdata;
    logic        psel, penable, pwrite, pready, pslverr;
    logic [7:0]  r_data, w_data, en_data;
    logic        interrupt;

    int n_checks = 0;
    int n_fail   = 0;

    gpio_ext #(.NUM_PINS(8), .SYNC_STAGES(S), .FILT_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .PADDR(paddr), .PSEL(psel), .PENABLE(penable),
        .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready),
        .PSLVERR(pslverr), .r_data(r_data), .w_data(w_data), .en_data(en_data),
        .interrupt(interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] m_w, m_en, m_ie, m_pos, m_neg, m_stat, m_lvl, m_fen, m_filt, m_prev;
    logic [3:0] m_thr;
    logic       m_irq;
    int         m_run [8];
    logic [7:0] sq [$];  // r_data samples, newest first

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] cur_syn();
        return (sq.size() >= S) ? sq[S-1] : 8'h00;
    endfunction

    function automatic logic [7:0] cur_filt();
        logic [7:0] syn = cur_syn();
        return (m_fen & m_filt) | (~m_fen & syn);
    endfunction

    function automatic logic m_err(input logic wr, input logic [7:0] a);
        logic known = (a <= 8'h30) && (a[1:0] == 2'b00);
        if (!known) return 1'b1;
        if (wr) return a == 8'h18;
        return a == 8'h14 || a == 8'h28 || a == 8'h2C || a == 8'h30;
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] a);
        case (a)
            8'h00:   return {24'h0, cur_filt()};
            8'h04:   return {24'h0, m_en};
            8'h08:   return {24'h0, m_ie};
            8'h0C:   return {24'h0, m_pos};
            8'h10:   return {24'h0, m_neg};
            8'h18:   return {24'h0, m_stat};
            8'h1C:   return {24'h0, m_lvl};
            8'h20:   return {24'h0, m_fen};
            8'h24:   return {28'h0, m_thr};
            default: return 32'h0;
        endcase
    endfunction

    // Advance model by one clock using the inputs currently applied, clock DUT, compare.
    task automatic step();
        logic [7:0] syn, fnow, ev, clr, a, d;
        logic irq_n, wr_ok;
        a = paddr[7:0];
        d = pwdata[7:0];
        ev = '0;
        if (rst) begin
            {m_w, m_en, m_ie, m_pos, m_neg, m_stat, m_lvl, m_fen, m_filt, m_prev} = '0;
            m_thr = '0;
            m_irq = 1'b0;
            for (int i = 0; i < 8; i++) m_run[i] = 0;
            sq.delete();
        end else begin
            syn  = cur_syn();
            fnow = cur_filt();
            for (int i = 0; i < 8; i++) begin
                if (m_lvl[i]) ev[i] = fnow[i] ? m_pos[i] : m_neg[i];
                else ev[i] = (fnow[i] && !m_prev[i] && m_pos[i]) ||
                             (!fnow[i] && m_prev[i] && m_neg[i]);
            end
            wr_ok  = psel && penable && pwrite && !m_err(1'b1, a);
            clr    = (wr_ok && a == 8'h14) ? d : 8'h00;
            irq_n  = |(m_stat & m_ie);
            m_stat = (m_stat & ~clr) | (ev & m_ie);
            for (int i = 0; i < 8; i++) begin
                if (!m_fen[i] || syn[i] == m_filt[i]) begin
                    m_filt[i] = syn[i];
                    m_run[i]  = 0;
                end else begin
                    m_run[i]++;
                    if (m_run[i] > int'(m_thr)) begin
                        m_filt[i] = syn[i];
                        m_run[i]  = 0;
                    end
                end
            end
            m_prev = fnow;
            if (wr_ok) begin
                case (a)
                    8'h00: m_w   = d;
                    8'h04: m_en  = d;
                    8'h08: m_ie  = d;
                    8'h0C: m_pos = d;
                    8'h10: m_neg = d;
                    8'h1C: m_lvl = d;
                    8'h20: m_fen = d;
                    8'h24: m_thr = pwdata[3:0];
                    8'h28: m_w   = m_w | d;
                    8'h2C: m_w   = m_w & ~d;
                    8'h30: m_w   = m_w ^ d;
                    default: ;
                endcase
                if (a == 8'h20 || a == 8'h24) for (int i = 0; i < 8; i++) m_run[i] = 0;
            end
            sq.push_front(r_data);
            if (sq.size() > S) void'(sq.pop_back());
            m_irq = irq_n;
        end
        @(posedge clk);
        #1;
        check("w_data", {24'h0, w_data}, {24'h0, m_w});
        check("en_data", {24'h0, en_data}, {24'h0, m_en});
        check("interrupt", {31'h0, interrupt}, {31'h0, m_irq});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic apb(input logic wr, input logic [7:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er);
        logic exp_err;
        paddr   = {24'h0, a};
        pwrite  = wr;
        pwdata  = d;
        psel    = 1'b1;
        penable = 1'b0;
        #1;
        check("prdata_setup", prdata, 32'h0);
        check("pslverr_setup", {31'h0, pslverr}, 32'h0);
        step();
        penable = 1'b1;
        #1;
        exp_err = m_err(wr, a);
        check("pready", {31'h0, pready}, 32'h1);
        check("pslverr", {31'h0, pslverr}, {31'h0, exp_err});
        check("prdata", prdata, (wr || exp_err) ? 32'h0 : m_read(a));
        rd = prdata;
        er = pslverr;
        step();
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    task automatic apb_wr(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] rd;
        logic er;
        apb(1'b1, a, d, rd, er);
    endtask

    task automatic apb_rd(input logic [7:0] a, output logic [31:0] v, output logic er);
        apb(1'b0, a, 32'h0, v, er);
    endtask

    initial begin
        logic [31:0] v;
        logic er;
        int n;
        logic [7:0] addrs [16];
        addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C,
                  8'h20, 8'h24, 8'h28, 8'h2C, 8'h30, 8'h40, 8'h03, 8'hFC};

        rst = 1'b1; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; r_data = 8'h00;
        idle(2);
        check("reset_prdata", prdata, 32'h0);
        rst = 1'b0;
        idle(1);

        // Output latch and SET/CLR/TGL
        apb_wr(8'h00, 32'hAA);
        apb_wr(8'h04, 32'hFF);
        r_data = 8'hAA;
        idle(3);
        apb_rd(8'h00, v, er);
        check("data_read_aa", v, 32'hAA);
        apb_wr(8'h28, 32'h01);
        apb_wr(8'h2C, 32'h80);
        apb_wr(8'h30, 32'h0F);
        check("w_data_24", {24'h0, w_data}, 32'h24);

        // Input read-back and unmapped offset
        apb_wr(8'h04, 32'h0);
        r_data = 8'h55;
        idle(S + 1);
        apb_rd(8'h00, v, er);
        check("data_read_55", v, 32'h55);
        apb_rd(8'h40, v, er);
        check("unmapped_err", {31'h0, er}, 32'h1);
        apb_wr(8'h18, 32'hFF);
        check("upper_ignored", {24'h0, en_data}, 32'h0);

        // Edge interrupts and latency
        r_data = 8'h00;
        idle(S + 2);
        apb_wr(8'h08, 32'h55);
        apb_wr(8'h0C, 32'h11);
        apb_wr(8'h10, 32'h44);
        idle(2);
        r_data = 8'hFF;
        n = 0;
        do begin step(); n++; end while (!interrupt && n < 20);
        check("irq_latency", n, S + 2);
        apb_rd(8'h18, v, er);
        check("stat_rise", v, 32'h11);
        apb_wr(8'h14, 32'h11);
        idle(2);
        check("irq_cleared", {31'h0, interrupt}, 32'h0);

        r_data = 8'h0F;
        idle(S + 2);
        apb_rd(8'h18, v, er);
        check("stat_fall", v, 32'h40);
        apb_wr(8'h14, 32'h40);
        r_data = 8'h4F;
        idle(S + 2);
        r_data = 8'h0F;
        idle(S - 1);
        apb_wr(8'h14, 32'h40);  // access edge coincides with the new fall event
        apb_rd(8'h18, v, er);
        check("set_wins", {31'h0, v[6]}, 32'h1);
        apb_wr(8'h14, 32'hFF);

        // Glitch filter on pin 0
        r_data = 8'h00;
        apb_wr(8'h24, 32'h3);
        apb_wr(8'h20, 32'h01);
        idle(S + 6);
        apb_wr(8'h14, 32'hFF);
        r_data = 8'h01; idle(3); r_data = 8'h00;
        idle(S + 8);
        apb_rd(8'h18, v, er);
        check("filt_short", {31'h0, v[0]}, 32'h0);
        check("filt_short_irq", {31'h0, interrupt}, 32'h0);
        r_data = 8'h01; idle(4); r_data = 8'h00;
        idle(S + 8);
        apb_rd(8'h18, v, er);
        check("filt_long", {31'h0, v[0]}, 32'h1);

        // Level mode re-set after clear
        apb_wr(8'h20, 32'h00);
        apb_wr(8'h1C, 32'h01);
        apb_wr(8'h0C, 32'h01);
        r_data = 8'h01;
        idle(S + 3);
        apb_wr(8'h14, 32'h01);
        apb_rd(8'h18, v, er);
        check("level_reset", {31'h0, v[0]}, 32'h1);

        // Reset during an access phase
        paddr = 32'h0; pwdata = 32'h5A; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
        step();
        penable = 1'b1;
        rst = 1'b1;
        #1;
        check("rst_pslverr", {31'h0, pslverr}, 32'h0);
        check("rst_prdata", prdata, 32'h0);
        step();
        check("rst_w_data", {24'h0, w_data}, 32'h0);
        rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        idle(2);
        check("rst_no_commit", {24'h0, w_data}, 32'h0);

        // Randomized traffic
        apb_wr(8'h24, 32'h1);
        for (int it = 0; it < 400; it++) begin
            case ($urandom_range(0, 5))
                0, 1: r_data = 8'($urandom);
                2: r_data = r_data ^ (8'h01 << $urandom_range(0, 7));
                3: idle($urandom_range(1, 4));
                4: begin
                    logic [7:0] a = addrs[$urandom_range(0, 15)];
                    logic [31:0] d = $urandom;
                    if (a == 8'h24) d = d & 32'hFFFF_FFF3;
                    apb_wr(a, d);
                end
                default: apb_rd(addrs[$urandom_range(0, 15)], v, er);
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
